// File: rtl/mixer_n_if.sv
// mixer_n_if: slot stream, register bus and stereo output of the mixer
interface mixer_n_if #(
  parameter int O_WIDTH  = 2,
  parameter int SAMPLE_W = 17,
  parameter int OUT_W    = 16
);
  logic                       slot_valid;
  logic                       slot_last;
  logic [O_WIDTH-1:0]         slot_osc;
  logic signed [SAMPLE_W-1:0] sample;
  logic signed [7:0]          env_lvl;
  logic [7:0]                 data;
  logic [6:0]                 adr;
  logic                       write;
  logic                       osc_sel;
  logic                       com_sel;
  logic                       ovf_clr;
  logic signed [OUT_W-1:0]    lsound_out;
  logic signed [OUT_W-1:0]    rsound_out;
  logic                       out_valid;
  logic                       frame_ovf;
  modport master (
    output slot_valid, slot_last, slot_osc, sample, env_lvl,
    output data, adr, write, osc_sel, com_sel, ovf_clr,
    input  lsound_out, rsound_out, out_valid, frame_ovf
  );
  modport slave (
    input  slot_valid, slot_last, slot_osc, sample, env_lvl,
    input  data, adr, write, osc_sel, com_sel, ovf_clr,
    output lsound_out, rsound_out, out_valid, frame_ovf
  );
endinterface

// File: rtl/mixer_n.sv
// mixer_n: pipelined stereo slot mixer with frame accumulate, master volume and shift.
// MIXER_SAT_EN selects saturation (and frame_ovf) instead of two's-complement wrap.
module mixer_n #(
  parameter int VOICES    = 8,
  parameter int V_OSC     = 4,
  parameter int V_WIDTH   = $clog2(VOICES),
  parameter int O_WIDTH   = $clog2(V_OSC),
  parameter int SAMPLE_W  = 17,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 39,
  parameter int ACC_W     = SAMPLE_W + 24 + V_WIDTH + O_WIDTH + 1
) (
  input logic      sCLK_XVXENVS,
  input logic      iRST_N,
  mixer_n_if.slave bus
);
  localparam int P1_W = SAMPLE_W + 8;
  localparam int P2_W = P1_W + 8;
  localparam int P3_W = P2_W + 8;
  localparam int MV_W = ACC_W + 8;
  logic signed [7:0]       lvl_q [V_OSC];
  logic [6:0]              pan_q [V_OSC];
  logic signed [7:0]       mvol_q;
  logic                    v1_q, l1_q, v2_q, l2_q, v3_q, l3_q, v4_q, v5_q;
  logic [O_WIDTH-1:0]      o1_q, o2_q;
  logic signed [P1_W-1:0]  p1_q;
  logic signed [P2_W-1:0]  p2_q;
  logic signed [P3_W-1:0]  pl_q, pr_q;
  logic signed [ACC_W-1:0] accl_q, accr_q, finl_q, finr_q, accl_d, accr_d;
  logic signed [MV_W-1:0]  mvl_q, mvr_q;
  logic signed [OUT_W-1:0] lo_q, ro_q, lo_d, ro_d;
  logic                    ov_q, ovf_q, ovl_d, ovr_d, ovf_d;
  function automatic logic [OUT_W:0] fit(input logic signed [MV_W-1:0] x);
    logic signed [MV_W-1:0] s;
    logic o;
    s = x >>> OUT_SHIFT;
`ifdef MIXER_SAT_EN
    o = !((&s[MV_W-1:OUT_W-1]) || !(|s[MV_W-1:OUT_W-1]));
    return {o, o ? {s[MV_W-1], {(OUT_W-1){~s[MV_W-1]}}} : s[OUT_W-1:0]};
`else
    o = 1'b0;
    return {o, s[OUT_W-1:0]};
`endif
  endfunction
  always_comb begin
    accl_d = accl_q + ACC_W'(pl_q);
    accr_d = accr_q + ACC_W'(pr_q);
    {ovl_d, lo_d} = fit(mvl_q);
    {ovr_d, ro_d} = fit(mvr_q);
    ovf_d = (v5_q & (ovl_d | ovr_d)) | (ovf_q & ~bus.ovf_clr);
  end
  always_ff @(posedge sCLK_XVXENVS or negedge iRST_N)
    if (!iRST_N) begin
      for (int n = 0; n < V_OSC; n++) begin
        lvl_q[n] <= (n < 2) ? 8'sh40 : 8'sh00;
        pan_q[n] <= 7'h40;
      end
      mvol_q <= 8'sh40;
      {v1_q, l1_q, v2_q, l2_q, v3_q, l3_q, v4_q, v5_q} <= '0;
      o1_q <= '0;
      o2_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      pl_q <= '0;
      pr_q <= '0;
      accl_q <= '0;
      accr_q <= '0;
      finl_q <= '0;
      finr_q <= '0;
      mvl_q <= '0;
      mvr_q <= '0;
      lo_q <= '0;
      ro_q <= '0;
      ov_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (bus.write) begin
        if (bus.osc_sel) begin
          for (int n = 0; n < V_OSC; n++) begin
            if (bus.adr == 7'(2 + (n << 4))) lvl_q[n] <= bus.data;
            if (bus.adr == 7'(7 + (n << 4))) pan_q[n] <= bus.data[6:0];
          end
        end else if (bus.com_sel && bus.adr == 7'd1) mvol_q <= bus.data;
      end
      v1_q <= bus.slot_valid;
      l1_q <= bus.slot_valid & bus.slot_last;
      o1_q <= bus.slot_osc;
      p1_q <= P1_W'(bus.sample) * P1_W'(bus.env_lvl);
      v2_q <= v1_q;
      l2_q <= l1_q;
      o2_q <= o1_q;
      p2_q <= P2_W'(p1_q) * P2_W'(lvl_q[o1_q]);
      v3_q <= v2_q;
      l3_q <= l2_q;
      pl_q <= P3_W'(p2_q) * P3_W'($signed({1'b0, 7'd127 - pan_q[o2_q]}));
      pr_q <= P3_W'(p2_q) * P3_W'($signed({1'b0, pan_q[o2_q]}));
      // the last slot closes the frame and restarts the accumulator in the same edge
      if (v3_q) begin
        accl_q <= l3_q ? '0 : accl_d;
        accr_q <= l3_q ? '0 : accr_d;
      end
      if (v3_q && l3_q) begin
        finl_q <= accl_d;
        finr_q <= accr_d;
      end
      v4_q <= v3_q & l3_q;
      v5_q <= v4_q;
      if (v4_q) begin
        mvl_q <= MV_W'(finl_q) * MV_W'(mvol_q);
        mvr_q <= MV_W'(finr_q) * MV_W'(mvol_q);
      end
      if (v5_q) begin
        lo_q <= lo_d;
        ro_q <= ro_d;
      end
      ov_q <= v5_q;
      ovf_q <= ovf_d;
    end
  assign bus.lsound_out = lo_q;
  assign bus.rsound_out = ro_q;
  assign bus.out_valid  = ov_q;
  assign bus.frame_ovf  = ovf_q;
endmodule

// File: tb/tb_mixer_n.sv
// tb_mixer_n: table-driven frame vectors plus register, back-to-back and reset sequences
module tb_mixer_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mixer_n_if #(.O_WIDTH(2), .SAMPLE_W(17), .OUT_W(16)) bus();
  mixer_n #(.OUT_SHIFT(20)) dut (.sCLK_XVXENVS(clk), .iRST_N(rst_n), .bus(bus));
`ifdef MIXER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  int passed = 0;
  int total = 0;
  int cyc = 0;
  typedef struct {int c; int l; int r;} ev_t;
  ev_t q[$];
  typedef struct {string n; int o; int s; int e; int k; int lw; int rw; int ls; int rs; bit ov;} vec_t;
  vec_t v[8];
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.out_valid) q.push_back('{cyc, int'(bus.lsound_out), int'(bus.rsound_out)});
  end
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d, expected %0d", n, a, e);
  endtask
  task automatic idle();
    bus.slot_valid = 1'b0;
    bus.slot_last = 1'b0;
    bus.write = 1'b0;
  endtask
  task automatic slot(input bit last, input int o, input int s, input int e);
    @(negedge clk);
    bus.slot_valid = 1'b1;
    bus.slot_last = last;
    bus.slot_osc = 2'(o);
    bus.sample = 17'(s);
    bus.env_lvl = 8'(e);
  endtask
  task automatic bubble();
    @(negedge clk);
    idle();
  endtask
  task automatic wr(input bit os, input bit cs, input int a, input int d);
    @(negedge clk);
    idle();
    bus.write = 1'b1;
    bus.osc_sel = os;
    bus.com_sel = cs;
    bus.adr = 7'(a);
    bus.data = 8'(d);
    @(negedge clk);
    bus.write = 1'b0;
  endtask
  task automatic expect_frame(input string n, input int c0, input int l, input int r);
    bubble();
    repeat (9) @(negedge clk);
    chk({n, ".pulses"}, q.size(), 1);
    if (q.size() > 0) begin
      chk({n, ".latency"}, q[0].c - c0, 6);
      chk({n, ".L"}, q[0].l, l);
      chk({n, ".R"}, q[0].r, r);
    end
    chk({n, ".hold"}, int'(bus.lsound_out), l);
    q.delete();
  endtask
  task automatic frame(input string n, input int o, input int s, input int e, input int k, input int l, input int r);
    int c0;
    for (int i = 1; i <= k; i++) slot(i == k, o, s, e);
    c0 = cyc;
    expect_frame(n, c0, l, r);
  endtask
  initial begin
    int ca, cb;
    v[0] = '{"one_pos", 0, 1000, 127, 1, 31253, 31750, 31253, 31750, 1'b0};
    v[1] = '{"one_neg", 0, -1000, 127, 1, -31254, -31750, -31254, -31750, 1'b0};
    v[2] = '{"two_pos", 0, 1000, 127, 2, -3029, -2036, 32767, 32767, 1'b1};
    v[3] = '{"two_neg", 0, -1000, 127, 2, 3028, 2036, -32768, -32768, 1'b1};
    v[4] = '{"osc1", 1, 500, 64, 1, 7875, 8000, 7875, 8000, 1'b0};
    v[5] = '{"osc2_mute", 2, 1000, 127, 1, 0, 0, 0, 0, 1'b0};
    v[6] = '{"small", 0, 2000, 10, 1, 4921, 5000, 4921, 5000, 1'b0};
    v[7] = '{"extreme", 0, -65536, -128, 1, -32768, 0, 32767, 32767, 1'b1};
    idle();
    bus.slot_osc = '0;
    bus.sample = '0;
    bus.env_lvl = '0;
    bus.data = '0;
    bus.adr = '0;
    bus.osc_sel = 1'b0;
    bus.com_sel = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.L", int'(bus.lsound_out), 0);
    chk("rst.R", int'(bus.rsound_out), 0);
    chk("rst.valid", int'(bus.out_valid), 0);
    chk("rst.ovf", int'(bus.frame_ovf), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.ovf_clr = 1'b1;
      @(negedge clk);
      bus.ovf_clr = 1'b0;
      frame(v[i].n, v[i].o, v[i].s, v[i].e, v[i].k, SAT ? v[i].ls : v[i].lw, SAT ? v[i].rs : v[i].rw);
      chk({v[i].n, ".ovf"}, int'(bus.frame_ovf), int'(SAT & v[i].ov));
    end
    // ovf_clr held across a saturating frame: the set wins, the next cycle clears
    @(negedge clk);
    bus.ovf_clr = 1'b1;
    slot(1'b0, 0, 1000, 127);
    slot(1'b1, 0, 1000, 127);
    @(negedge clk);
    idle();
    repeat (5) @(posedge clk);
    #2;
    chk("ovfprio.valid", int'(bus.out_valid), 1);
    chk("ovfprio.set", int'(bus.frame_ovf), int'(SAT));
    @(posedge clk);
    #2;
    chk("ovfprio.clr", int'(bus.frame_ovf), 0);
    bus.ovf_clr = 1'b0;
    repeat (5) @(negedge clk);
    q.delete();
    wr(1'b0, 1'b1, 1, 0);
    frame("mvol0", 0, 1000, 127, 1, 0, 0);
    wr(1'b0, 1'b1, 1, 8'h40);
    wr(1'b1, 1'b1, 1, 0);
    frame("osc_prio", 0, 1000, 127, 1, 31253, 31750);
    wr(1'b1, 1'b0, 7, 0);
    frame("pan0", 0, 100, 127, 1, 6300, 0);
    wr(1'b1, 1'b0, 7, 8'h40);
    wr(1'b0, 1'b1, 34, 8'h40);
    frame("lvl2_com", 2, 1000, 127, 1, 0, 0);
    wr(1'b1, 1'b0, 34, 8'h40);
    frame("lvl2_osc", 2, 1000, 127, 1, 31253, 31750);
    slot(1'b1, 0, 1000, 127);
    ca = cyc;
    slot(1'b0, 1, 500, 64);
    bubble();
    slot(1'b0, 0, 2000, 10);
    bubble();
    slot(1'b1, 1, 500, 64);
    cb = cyc;
    bubble();
    repeat (9) @(negedge clk);
    chk("b2b.pulses", q.size(), 2);
    if (q.size() == 2) begin
      chk("b2b.A.latency", q[0].c - ca, 6);
      chk("b2b.A.L", q[0].l, 31253);
      chk("b2b.A.R", q[0].r, 31750);
      chk("b2b.B.latency", q[1].c - cb, 6);
      chk("b2b.B.L", q[1].l, 20671);
      chk("b2b.B.R", q[1].r, 21000);
    end
    q.delete();
    slot(1'b0, 0, 1000, 127);
    slot(1'b1, 0, 1000, 127);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    chk("abort.rst_L", int'(bus.lsound_out), 0);
    chk("abort.rst_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort.nopulse", q.size(), 0);
    q.delete();
    frame("after_rst", 0, 1000, 127, 1, 31253, 31750);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
